matrix_result_collector: RTL and testbench
==========================================

Name: matrix_result_collector

Overview:
- Consumer end of the 3x3 matrix multiplier's result interface: captures the c_out/c_valid/row/col stream and the done pulse.
- Descales each raw accumulator value by the fixed-point scale using signed truncating division by SCALE, saturates it to DATA_WIDTH and stores it in a 9-entry result buffer.
- Exposes a registered random-access read port for the downstream tracker/Kalman datapath.

Parameters:
- DATA_WIDTH, 32, width of descaled result words.
- ACC_WIDTH, 66, width of raw multiplier accumulator; equals 2*DATA_WIDTH+2.
- SCALE, 1000, fixed-point scale divisor; must be >= 1.
- MAT_SIZE, 9, number of result elements; entry index = row*3 + col.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- c_in  in  ACC_WIDTH  signed raw result from the multiplier's c_out.
- c_valid  in  1  c_in/row/col are valid this cycle.
- row  in  2  result row, 0..2.
- col  in  2  result column, 0..2.
- mult_done  in  1  one-cycle pulse from the multiplier: stream complete.
- clear  in  1  synchronous soft clear.
- rd_en  in  1  read request.
- rd_addr  in  4  read index, 0..8.
- rd_data  out  DATA_WIDTH  signed descaled result.
- rd_valid  out  1  rd_data is valid; asserted one cycle after rd_en.
- busy  out  1  high in the DIVIDE state.
- results_ready  out  1  all 9 descaled results are stored.
- sat_flag  out  1  sticky: at least one quotient was clamped.
- err_flag  out  1  sticky: overrun, bad index or missing element.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE. rd_data=0, rd_valid=0, busy=0, results_ready=0, sat_flag=0, err_flag=0. Raw buffer, result buffer and per-entry received bits are all cleared to 0. Reset in any state, including mid-divide, aborts the operation.
- clear: same effect as rst, except the result buffer is not cleared.
- States: IDLE, CAPTURE, DIVIDE, DONE.
- IDLE/CAPTURE/DONE, c_valid=1:
  - Write c_in to raw[row*3+col] and set the received bit for that entry.
  - A first c_valid moves the block to CAPTURE; in DONE it also clears results_ready.
  - Repeated writes to the same index overwrite; last value wins.
  - row==3 or col==3: sample is dropped and err_flag is set.
- mult_done=1 in IDLE/CAPTURE/DONE at edge k:
  - Enter DIVIDE at k+1 and set busy.
  - If any received bit is 0, set err_flag; missing entries divide as 0.
  - If c_valid and mult_done arrive in the same cycle, the sample is captured before DIVIDE starts.
- DIVIDE:
  - Processes entries 0..8 in order, ACC_WIDTH+2 cycles per entry:
    - 1 LOAD cycle: take the magnitude and record the sign.
    - ACC_WIDTH restoring-division iterations on the magnitude, divisor SCALE.
    - 1 WRITE cycle: negate the quotient if the operand was negative (truncation toward zero), saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and write the result buffer. sat_flag is set when the quotient is clamped.
  - results_ready rises registered at edge k+1+9*(ACC_WIDTH+2), which is 613 cycles at defaults.
  - At the same edge: busy=0, state=DONE, received bits are cleared.
  - c_valid or mult_done during DIVIDE: input is ignored and err_flag is set (overrun).
- Read port:
  - Legal in every state. rd_en at edge t gives rd_data=result[rd_addr] and rd_valid=1 at t+1.
  - rd_addr >= 9: rd_data=0, err_flag unaffected.
  - rd_valid=0 on cycles with no request.
  - A read during DIVIDE returns the current buffer content, which may be stale or partially updated.
- A simultaneous read and WRITE to the same entry returns the old value.

Optional Feature:
- DESCALE_ROUND_EN:
  - Defined: the WRITE cycle rounds half away from zero. It adds 1 to the magnitude quotient when 2*remainder >= SCALE, before sign restore and saturation. Latency is unchanged.
  - Undefined: pure truncation toward zero.

Test Plan:
- Identity*1000 times B column [1000,2000,3000], all other elements 0, then mult_done -> reads 0/3/6 return 1000/2000/3000, all others 0, results_ready 613 cycles after mult_done, sat_flag=0, err_flag=0.
- c_in=-1,500,499 at (0,0) -> rd_data=-1500; with DESCALE_ROUND_EN defined, c_in=-1,500,500 -> -1501.
- c_in=5,000,000,000,000 -> rd_data=2147483647 and sat_flag=1; c_in=-5,000,000,000,000 -> -2147483648.
- Only 8 of 9 elements sent, then mult_done -> err_flag=1 and the missing entry reads 0. A separate run driving c_valid during DIVIDE -> err_flag=1 and results unaffected.
- Assert rst for one cycle mid-DIVIDE (e.g. 100 cycles in) -> next cycle busy=0, results_ready=0, every read returns 0; a fresh full run then completes correctly.
- clear in DONE -> results_ready=0, reads still return the prior results. Back-to-back reads at addresses 8 and 9 -> rd_valid on consecutive cycles, data = result[8], then 0.

Source files
------------

// File: rtl/matrix_result_collector.sv
// Consumer end of the 3x3 matrix multiplier: captures raw accumulators, descales each by SCALE
// with one shared serial restoring divider, saturates to DATA_WIDTH, and serves a registered read port.
// Optional macro DESCALE_ROUND_EN: round half away from zero instead of truncating toward zero.
module matrix_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 66,
  parameter int SCALE      = 1000,
  parameter int MAT_SIZE   = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [ACC_WIDTH-1:0]  c_in,
  input  logic                         c_valid,
  input  logic [1:0]                   row,
  input  logic [1:0]                   col,
  input  logic                         mult_done,
  input  logic                         clear,
  input  logic                         rd_en,
  input  logic [3:0]                   rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         busy,
  output logic                         results_ready,
  output logic                         sat_flag,
  output logic                         err_flag
);
  // Remainder never exceeds 2*SCALE-1 after the shift, so clog2(SCALE)+1 bits suffice.
  localparam int RW = $clog2(SCALE) + 1;
  localparam int QW = ACC_WIDTH + 1;
  localparam int CW = $clog2(ACC_WIDTH + 2);
  localparam logic [RW-1:0] SCALE_R  = RW'(SCALE);
  localparam logic [RW:0]   SCALE_R2 = (RW+1)'(SCALE);
  localparam logic [CW-1:0] ITERS    = CW'(ACC_WIDTH);
  localparam logic [3:0]    N_ENT    = 4'(MAT_SIZE);
  localparam logic [QW-1:0] POS_MAX  = {{(QW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [QW-1:0] NEG_MAG  = POS_MAX + QW'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DIVIDE, DONE} state_t;

  state_t                              state;
  logic [MAT_SIZE-1:0][ACC_WIDTH-1:0]  raw;
  logic [MAT_SIZE-1:0][DATA_WIDTH-1:0] result;
  logic [MAT_SIZE-1:0]                 rcvd;

  logic [3:0]           ent;
  logic [CW-1:0]        phase;
  logic [ACC_WIDTH-1:0] dq;
  logic [RW-1:0]        rem;
  logic                 neg;

  logic                 idx_ok;
  logic [3:0]           wr_idx;
  logic [MAT_SIZE-1:0]  wr_bit;

  always_comb begin
    idx_ok = (row != 2'd3) && (col != 2'd3);
    wr_idx = {2'b00, row} * 4'd3 + {2'b00, col};
    wr_bit = '0;
    if (c_valid && idx_ok) wr_bit[wr_idx] = 1'b1;
  end

  logic [3:0]            ent_i;
  logic [ACC_WIDTH-1:0]  op_sel;
  logic [ACC_WIDTH-1:0]  op_mag;
  logic                  op_neg;
  logic [RW-1:0]         rem_sh;
  logic                  sub_ok;
  logic                  rnd_up;
  logic [QW-1:0]         q_mag;
  logic                  clamp;
  logic [DATA_WIDTH-1:0] wval;

  always_comb begin
    ent_i  = (ent < N_ENT) ? ent : 4'd0;
    // Entries never received in this run divide as zero, whatever stale raw data remains.
    op_sel = rcvd[ent_i] ? raw[ent_i] : '0;
    op_neg = op_sel[ACC_WIDTH-1];
    op_mag = op_neg ? ('0 - op_sel) : op_sel;
    rem_sh = RW'({rem, dq[ACC_WIDTH-1]});
    sub_ok = rem_sh >= SCALE_R;
`ifdef DESCALE_ROUND_EN
    rnd_up = {rem, 1'b0} >= SCALE_R2;
`else
    rnd_up = 1'b0;
`endif
    q_mag = {1'b0, dq} + {{(QW-1){1'b0}}, rnd_up};
    clamp = neg ? (q_mag > NEG_MAG) : (q_mag > POS_MAX);
    if (clamp)
      wval = neg ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      wval = neg ? DATA_WIDTH'(~q_mag + QW'(1)) : q_mag[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state         <= IDLE;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      busy          <= 1'b0;
      results_ready <= 1'b0;
      sat_flag      <= 1'b0;
      err_flag      <= 1'b0;
      raw           <= '0;
      rcvd          <= '0;
      ent           <= '0;
      phase         <= '0;
      dq            <= '0;
      rem           <= '0;
      neg           <= 1'b0;
      if (rst) result <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (rd_addr < N_ENT) ? result[rd_addr] : '0;

      case (state)
        IDLE, CAPTURE, DONE: begin
          if (c_valid) begin
            if (idx_ok) begin
              raw[wr_idx]   <= c_in;
              rcvd[wr_idx]  <= 1'b1;
              state         <= CAPTURE;
              results_ready <= 1'b0;
            end else begin
              err_flag <= 1'b1;
            end
          end
          // A sample arriving with mult_done counts toward completeness.
          if (mult_done) begin
            state         <= DIVIDE;
            busy          <= 1'b1;
            results_ready <= 1'b0;
            ent           <= '0;
            phase         <= '0;
            if (!(&(rcvd | wr_bit))) err_flag <= 1'b1;
          end
        end

        DIVIDE: begin
          if (c_valid || mult_done) err_flag <= 1'b1;
          if (ent == N_ENT) begin
            state         <= DONE;
            busy          <= 1'b0;
            results_ready <= 1'b1;
            rcvd          <= '0;
          end else if (phase == '0) begin
            dq    <= op_mag;
            neg   <= op_neg;
            rem   <= '0;
            phase <= phase + CW'(1);
          end else if (phase <= ITERS) begin
            dq    <= {dq[ACC_WIDTH-2:0], sub_ok};
            rem   <= sub_ok ? (rem_sh - SCALE_R) : rem_sh;
            phase <= phase + CW'(1);
          end else begin
            result[ent] <= wval;
            if (clamp) sat_flag <= 1'b1;
            ent   <= ent + 4'd1;
            phase <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_collector.sv
// Bench for matrix_result_collector: table-driven descale corners, randomized runs against an
// arithmetic reference model, and hand-written sequences for reset/clear/overrun/missing cases.
module tb_matrix_result_collector;
  localparam int AW = 66;
  localparam int DW = 32;
  localparam int SC = 1000;
  localparam int MS = 9;
`ifdef DESCALE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                 clk = 1'b0;
  logic                 rst, c_valid, mult_done, clear, rd_en;
  logic signed [AW-1:0] c_in;
  logic [1:0]           row, col;
  logic [3:0]           rd_addr;
  logic signed [DW-1:0] rd_data;
  logic                 rd_valid, busy, results_ready, sat_flag, err_flag;

  matrix_result_collector dut (
    .clk(clk), .rst(rst), .c_in(c_in), .c_valid(c_valid), .row(row), .col(col),
    .mult_done(mult_done), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .results_ready(results_ready),
    .sat_flag(sat_flag), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  typedef struct {longint v; longint e; bit s;} vec_t;
  vec_t   tbl[MS];
  int     tests = 0;
  int     fails = 0;
  longint vals[MS];
  bit     mask[MS];
  longint expv[MS];
  bit     exps;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: signed division truncates toward zero, optional half-away rounding, then clamp.
  function automatic longint descale(input longint v, output bit s);
    longint q, r;
    q = v / SC;
    r = v % SC;
    if (RND && 2 * (r < 0 ? -r : r) >= SC) q = (v < 0) ? q - 1 : q + 1;
    s = 1'b0;
    if (q > MAXV) begin q = MAXV; s = 1'b1; end
    else if (q < MINV) begin q = MINV; s = 1'b1; end
    return q;
  endfunction

  function automatic longint rnd_val();
    longint r;
    r = {$urandom(), $urandom()};
    return r >>> $urandom_range(14, 58);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int idx, input longint v);
    c_valid = 1'b1;
    row     = 2'(idx / 3);
    col     = 2'(idx % 3);
    c_in    = {{(AW-64){v[63]}}, v};
    tick();
    c_valid = 1'b0;
  endtask

  // Random order, random idle gaps, and occasional garbage written first (last write must win).
  task automatic send_all();
    int ord[MS];
    int j, t;
    for (int i = 0; i < MS; i++) ord[i] = i;
    for (int i = 0; i < MS; i++) begin
      j = $urandom_range(i, MS - 1);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int k = 0; k < MS; k++) begin
      if (mask[ord[k]]) begin
        if ($urandom_range(0, 3) == 0) send(ord[k], longint'($urandom()));
        send(ord[k], vals[ord[k]]);
        if ($urandom_range(0, 1) == 1) tick();
      end
    end
  endtask

  task automatic compute_exp();
    bit s;
    exps = 1'b0;
    for (int i = 0; i < MS; i++) begin
      if (mask[i]) begin
        expv[i] = descale(vals[i], s);
        exps    = exps | s;
      end else begin
        expv[i] = 0;
      end
    end
  endtask

  task automatic rand_vals();
    for (int i = 0; i < MS; i++) begin
      vals[i] = rnd_val();
      mask[i] = 1'b1;
    end
  endtask

  // Pulse mult_done, then count edges until results_ready; inj >= 0 drives an overrun mid-divide.
  task automatic run_div(input string name, input int inj);
    int n;
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    check({name, " busy"}, busy, 1);
    n = 0;
    while (!results_ready && n < 700) begin
      c_valid   = (inj >= 0) && (n == inj);
      mult_done = (inj >= 0) && (n == inj + 1);
      if (c_valid) begin row = 2'd0; col = 2'd0; c_in = 66'sd987654321; end
      tick();
      n++;
    end
    c_valid   = 1'b0;
    mult_done = 1'b0;
    check({name, " latency"}, n, 613);
    check({name, " busy_end"}, busy, 0);
  endtask

  task automatic read_chk(input string name, input int addr, input longint exp);
    rd_en   = 1'b1;
    rd_addr = 4'(addr);
    tick();
    rd_en   = 1'b0;
    check({name, " valid"}, rd_valid, 1);
    check({name, " data"}, rd_data, exp);
  endtask

  task automatic read_all(input string name);
    for (int i = 0; i < MS; i++) read_chk($sformatf("%s[%0d]", name, i), i, expv[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit tsat;
    rst = 1'b1; c_valid = 1'b0; mult_done = 1'b0; clear = 1'b0; rd_en = 1'b0;
    c_in = '0; row = '0; col = '0; rd_addr = '0;

    tbl[0] = '{-64'sd1500499,        -64'sd1500,                 1'b0};
    tbl[1] = '{64'sd5000000000000,   64'sd2147483647,            1'b1};
    tbl[2] = '{-64'sd5000000000000,  -64'sd2147483648,           1'b1};
    tbl[3] = '{64'sd999,             RND ? 64'sd1 : 64'sd0,      1'b0};
    tbl[4] = '{-64'sd999,            RND ? -64'sd1 : 64'sd0,     1'b0};
    tbl[5] = '{64'sd2147483647000,   64'sd2147483647,            1'b0};
    tbl[6] = '{64'sd2147483648000,   64'sd2147483647,            1'b1};
    tbl[7] = '{-64'sd2147483648000,  -64'sd2147483648,           1'b0};
    tbl[8] = '{-64'sd1500500,        RND ? -64'sd1501 : -64'sd1500, 1'b0};

    // Reset state
    do_reset();
    check("rst rd_data", rd_data, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst busy", busy, 0);
    check("rst ready", results_ready, 0);
    check("rst sat", sat_flag, 0);
    check("rst err", err_flag, 0);
    read_chk("rst read0", 0, 0);

    // Identity * 1000 times column [1000,2000,3000]
    vals = '{64'sd1000000, 0, 0, 64'sd2000000, 0, 0, 64'sd3000000, 0, 0};
    for (int i = 0; i < MS; i++) mask[i] = 1'b1;
    send_all();
    compute_exp();
    run_div("ident", -1);
    read_chk("ident r0", 0, 1000);
    read_chk("ident r3", 3, 2000);
    read_chk("ident r6", 6, 3000);
    read_all("ident");
    check("ident sat", sat_flag, 0);
    check("ident err", err_flag, 0);

    // Descale/saturation corner table
    do_reset();
    tsat = 1'b0;
    for (int i = 0; i < MS; i++) begin
      vals[i] = tbl[i].v;
      mask[i] = 1'b1;
      tsat    = tsat | tbl[i].s;
    end
    send_all();
    run_div("tbl", -1);
    for (int i = 0; i < MS; i++) read_chk($sformatf("tbl[%0d]", i), i, tbl[i].e);
    check("tbl sat", sat_flag, tsat);
    check("tbl err", err_flag, 0);

    // Randomized runs against the reference model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      rand_vals();
      send_all();
      compute_exp();
      run_div($sformatf("rnd%0d", r), -1);
      read_all($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d sat", r), sat_flag, exps);
      check($sformatf("rnd%0d err", r), err_flag, 0);
    end

    // Missing element after a completed run: stale raw data must not leak into entry 4
    rand_vals();
    mask[4] = 1'b0;
    send_all();
    compute_exp();
    run_div("miss", -1);
    check("miss err", err_flag, 1);
    read_all("miss");

    // Overrun during DIVIDE: flagged, results unaffected
    do_reset();
    rand_vals();
    send_all();
    compute_exp();
    run_div("ovr", 200);
    check("ovr err", err_flag, 1);
    read_all("ovr");

    // Bad row/col indices
    for (int b = 0; b < 2; b++) begin
      do_reset();
      c_valid = 1'b1;
      row = (b == 0) ? 2'd3 : 2'd1;
      col = (b == 0) ? 2'd1 : 2'd3;
      c_in = 66'sd5;
      tick();
      c_valid = 1'b0;
      check($sformatf("badidx%0d err", b), err_flag, 1);
      check($sformatf("badidx%0d busy", b), busy, 0);
    end

    // Reset mid-DIVIDE aborts and clears results, then a fresh run completes
    do_reset();
    rand_vals();
    send_all();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    repeat (99) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid busy", busy, 0);
    check("rstmid ready", results_ready, 0);
    for (int i = 0; i < MS; i++) expv[i] = 0;
    read_all("rstmid");
    rand_vals();
    send_all();
    compute_exp();
    run_div("fresh", -1);
    read_all("fresh");
    check("fresh sat", sat_flag, exps);

    // Clear in DONE keeps results; back-to-back reads at 8 then 9
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr ready", results_ready, 0);
    check("clr sat", sat_flag, 0);
    read_all("clr");
    rd_en = 1'b1;
    rd_addr = 4'd8;
    tick();
    check("b2b 8 valid", rd_valid, 1);
    check("b2b 8 data", rd_data, expv[8]);
    rd_addr = 4'd9;
    tick();
    check("b2b 9 valid", rd_valid, 1);
    check("b2b 9 data", rd_data, 0);
    rd_en = 1'b0;
    tick();
    check("b2b idle valid", rd_valid, 0);
    check("b2b err", err_flag, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
